// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the processor output port and the UART transmit engine.
// Bytes are queued in a circular buffer and handed to the engine one at a time, paced on txrdy.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_strobe,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    input  logic          txrdy_in,
    output logic          tx_load,
    output logic [7:0]    tx_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_RDY
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;
    logic [AW:0]   count_next;

    // Pop looks only at registered occupancy, so a byte written this cycle is never popped this cycle.
    always_comb begin
        pop        = (state == IDLE) && !empty && txrdy_in;
        push       = wr_strobe && ((count != DEPTH_CNT) || pop);
        drop       = wr_strobe && !push;
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            ovf     <= 1'b0;
            tx_load <= 1'b0;
            tx_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);

            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end

            tx_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1'b1;
                        tx_load <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!txrdy_in) begin
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (txrdy_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
